read_id: RTL and testbench

// - NAND-flash Read-ID sequencer: on host command 0x90, issues CMD 0x90 then ADDR 0x00 with WE# strobes.
// - After a 2-cycle tWHR wait, strobes RE# four times, capturing 4 ID bytes from input_data.
// - Sits between the host command path and the NAND pin interface; internal state is exported for debug.

---
 rtl/read_id_pkg.sv | 41 ++++
 rtl/read_id_nand_toggle.sv | 39 +++
 rtl/read_id.sv | 152 +++++++++++++++
 tb/tb_read_id.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/read_id_pkg.sv
// Shared types and constants for the NAND Read-ID sequencer.
// The FSM encoding is exported on state_reg_tb, so the enum values are fixed.
package read_id_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_ADDR = 2'd2,
    ST_READ = 2'd3
  } state_e;

  localparam logic [7:0] CMD_READID = 8'h90;
  localparam logic [7:0] ID_ADDR    = 8'h00;
  localparam logic [7:0] BUS_IDLE   = 8'h00;

  // Bit positions inside the exported control vector {CLE, ALE, CE_n, WE_n, RE_n}
  localparam int unsigned VEC_CLE  = 4;
  localparam int unsigned VEC_ALE  = 3;
  localparam int unsigned VEC_CE_N = 2;
  localparam int unsigned VEC_WE_N = 1;
  localparam int unsigned VEC_RE_N = 0;

  localparam logic [4:0] VEC_IDLE = 5'b00111;

  localparam logic [1:0] DEVID_IDX   = 2'd1;
  localparam logic [1:0] LAST_ID_IDX = 2'd3;

  function automatic logic [4:0] pack_ctrl(input logic cle, input logic ale,
                                           input logic ce_n, input logic we_n,
                                           input logic re_n);
    logic [4:0] v;
    v           = '0;
    v[VEC_CLE]  = cle;
    v[VEC_ALE]  = ale;
    v[VEC_CE_N] = ce_n;
    v[VEC_WE_N] = we_n;
    v[VEC_RE_N] = re_n;
    return v;
  endfunction

endpackage

// File: rtl/read_id_nand_toggle.sv
// Strobe generator: while enabled, a 4-phase cycle with the strobe low for
// phases 0-1, high for 2-3, and a done pulse in phase 3.
module nand_toggle (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tog_n,
  output logic done
);

  logic [1:0] phase_q;
  logic [1:0] phase_d;

  always_comb begin
    phase_d = 2'd0;
    if (en) begin
      phase_d = phase_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q <= 2'd0;
    end else begin
      phase_q <= phase_d;
    end
  end

  // The phase counter is parked at 0 while disabled, so the strobe idles high
  always_comb begin
    tog_n = 1'b1;
    done  = 1'b0;
    if (en) begin
      tog_n = phase_q[1];
      done  = (phase_q == 2'd3);
    end
  end

endmodule

// File: rtl/read_id.sv
// NAND Read-ID sequencer: CMD 0x90, ADDR 0x00, tWHR wait, then four RE# strobes
// capturing the ID bytes. Internal state is exported on the *_tb ports for debug.
module read_id
  import read_id_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] input_data,
  output logic [7:0] output_data,
  output logic       IDread_done,
  output logic       toggleDone_tb,
  output logic       dummy_cnt_tb,
  output logic [1:0] state_reg_tb,
  output logic [1:0] IDread_cnt_tb,
  output logic [7:0] DevID_tb,
  output logic [4:0] outputVEC_tb
);

  state_e     state_q, state_d;
  logic       addr_sent_q, addr_sent_d;
  logic       dummy_q, dummy_d;
  logic [1:0] id_cnt_q, id_cnt_d;
  logic       done_q, done_d;
  logic [7:0] devid_q, devid_d;

  logic tog_en;
  logic tog_n;
  logic tog_done;

  // One strobe generator is shared: WE# in CMD/ADDR, RE# in READ
  assign tog_en = (state_q == ST_CMD)
               || ((state_q == ST_ADDR) && !addr_sent_q)
               || (state_q == ST_READ);

  nand_toggle u_toggle (
    .clk   (clk),
    .reset (reset),
    .en    (tog_en),
    .tog_n (tog_n),
    .done  (tog_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      addr_sent_q <= 1'b0;
      dummy_q     <= 1'b0;
      id_cnt_q    <= 2'd0;
      done_q      <= 1'b0;
      devid_q     <= 8'h00;
    end else begin
      state_q     <= state_d;
      addr_sent_q <= addr_sent_d;
      dummy_q     <= dummy_d;
      id_cnt_q    <= id_cnt_d;
      done_q      <= done_d;
      devid_q     <= devid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_sent_d = addr_sent_q;
    dummy_d     = dummy_q;
    id_cnt_d    = id_cnt_q;
    done_d      = done_q;
    devid_d     = devid_q;

    unique case (state_q)
      ST_IDLE: begin
        if (input_data == CMD_READID) begin
          state_d  = ST_CMD;
          done_d   = 1'b0;
          id_cnt_d = 2'd0;
        end
      end

      ST_CMD: begin
        if (tog_done) begin
          state_d = ST_ADDR;
        end
      end

      // addr_sent splits ADDR into the WE# strobe and the two-cycle tWHR wait
      ST_ADDR: begin
        if (!addr_sent_q) begin
          if (tog_done) begin
            addr_sent_d = 1'b1;
          end
        end else if (dummy_q) begin
          state_d     = ST_READ;
          dummy_d     = 1'b0;
          addr_sent_d = 1'b0;
        end else begin
          dummy_d = 1'b1;
        end
      end

      ST_READ: begin
        if (tog_done) begin
          if (id_cnt_q == DEVID_IDX) begin
            devid_d = input_data;
          end
          id_cnt_d = id_cnt_q + 2'd1;
          if (id_cnt_q == LAST_ID_IDX) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    output_data  = BUS_IDLE;
    outputVEC_tb = VEC_IDLE;
    unique case (state_q)
      ST_IDLE: begin
        output_data  = BUS_IDLE;
        outputVEC_tb = VEC_IDLE;
      end
      ST_CMD: begin
        output_data  = CMD_READID;
        outputVEC_tb = pack_ctrl(1'b1, 1'b0, 1'b0, tog_n, 1'b1);
      end
      ST_ADDR: begin
        output_data  = ID_ADDR;
        outputVEC_tb = pack_ctrl(1'b0, 1'b1, 1'b0, tog_n, 1'b1);
      end
      ST_READ: begin
        output_data  = BUS_IDLE;
        outputVEC_tb = pack_ctrl(1'b0, 1'b0, 1'b0, 1'b1, tog_n);
      end
      default: begin
        output_data  = BUS_IDLE;
        outputVEC_tb = VEC_IDLE;
      end
    endcase
  end

  assign IDread_done   = done_q;
  assign toggleDone_tb = tog_done;
  assign dummy_cnt_tb  = dummy_q;
  assign state_reg_tb  = state_q;
  assign IDread_cnt_tb = id_cnt_q;
  assign DevID_tb      = devid_q;

endmodule

// File: tb/tb_read_id.sv
// Directed testbench for read_id: full Read-ID sequences, back-to-back restart,
// non-matching commands, and an asynchronous reset in the middle of READ.
module tb_read_id;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] input_data;
  logic [7:0] output_data;
  logic       IDread_done;
  logic       toggleDone_tb;
  logic       dummy_cnt_tb;
  logic [1:0] state_reg_tb;
  logic [1:0] IDread_cnt_tb;
  logic [7:0] DevID_tb;
  logic [4:0] outputVEC_tb;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  read_id dut (
    .clk          (clk),
    .reset        (reset),
    .input_data   (input_data),
    .output_data  (output_data),
    .IDread_done  (IDread_done),
    .toggleDone_tb(toggleDone_tb),
    .dummy_cnt_tb (dummy_cnt_tb),
    .state_reg_tb (state_reg_tb),
    .IDread_cnt_tb(IDread_cnt_tb),
    .DevID_tb     (DevID_tb),
    .outputVEC_tb (outputVEC_tb)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d);
    input_data = d;
  endtask

  task automatic nextCycle();
    @(negedge clk);
  endtask

  task automatic checkPins(input string tag, input logic [1:0] st, input logic [7:0] od,
                           input logic [4:0] vec, input logic tog);
    checkOutput($sformatf("%s.state", tag), 32'(state_reg_tb), 32'(st));
    checkOutput($sformatf("%s.data", tag), 32'(output_data), 32'(od));
    checkOutput($sformatf("%s.vec", tag), 32'(outputVEC_tb), 32'(vec));
    checkOutput($sformatf("%s.tog", tag), 32'(toggleDone_tb), 32'(tog));
  endtask

  task automatic checkResetValues(input string tag);
    checkPins(tag, 2'd0, 8'h00, 5'b00111, 1'b0);
    checkOutput($sformatf("%s.done", tag), 32'(IDread_done), 32'd0);
    checkOutput($sformatf("%s.devid", tag), 32'(DevID_tb), 32'd0);
    checkOutput($sformatf("%s.cnt", tag), 32'(IDread_cnt_tb), 32'd0);
    checkOutput($sformatf("%s.dummy", tag), 32'(dummy_cnt_tb), 32'd0);
  endtask

  // CMD (4 cycles) then ADDR (4 strobe + 2 wait); optional junk on input_data
  task automatic runHead(input string tag, input logic junk);
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      checkPins($sformatf("%s.cmd%0d", tag, i), 2'd1, 8'h90,
                {1'b1, 1'b0, 1'b0, (i >= 2), 1'b1}, (i == 3));
      if (i == 0) checkOutput($sformatf("%s.doneclr", tag), 32'(IDread_done), 32'd0);
      if (junk) applyStimulus(8'h5A + 8'(i));
    end
    for (int i = 0; i < 6; i++) begin
      nextCycle();
      checkPins($sformatf("%s.addr%0d", tag, i), 2'd2, 8'h00,
                {1'b0, 1'b1, 1'b0, (i >= 2), 1'b1}, (i == 3));
      if (i >= 4) checkOutput($sformatf("%s.dummy%0d", tag, i), 32'(dummy_cnt_tb), 32'(i - 4));
      if (junk) applyStimulus(8'hA0 + 8'(i));
    end
  endtask

  // READ: 16 cycles, byte k driven during strobe k; then IDLE with done set
  task automatic runRead(input string tag, input logic [31:0] bytes, input logic [7:0] expDev);
    for (int i = 0; i < 16; i++) begin
      nextCycle();
      checkPins($sformatf("%s.rd%0d", tag, i), 2'd3, 8'h00,
                {1'b0, 1'b0, 1'b0, 1'b1, ((i % 4) >= 2)}, ((i % 4) == 3));
      checkOutput($sformatf("%s.cnt%0d", tag, i), 32'(IDread_cnt_tb), 32'(i / 4));
      checkOutput($sformatf("%s.busy%0d", tag, i), 32'(IDread_done), 32'd0);
      applyStimulus(bytes[31 - 8 * (i / 4) -: 8]);
    end
    nextCycle();
    checkPins($sformatf("%s.end", tag), 2'd0, 8'h00, 5'b00111, 1'b0);
    checkOutput($sformatf("%s.done", tag), 32'(IDread_done), 32'd1);
    checkOutput($sformatf("%s.devid", tag), 32'(DevID_tb), 32'(expDev));
    checkOutput($sformatf("%s.cntwrap", tag), 32'(IDread_cnt_tb), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    applyStimulus(8'h00);
    #100;
    checkResetValues("por");
    reset = 1'b1;
    nextCycle();
    checkResetValues("idle");

    // Non-matching commands are ignored
    applyStimulus(8'h91);
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      checkOutput($sformatf("nocmd%0d", i), 32'(state_reg_tb), 32'd0);
    end

    // Run 1: 0x90 held throughout, DevID captures 0x90
    applyStimulus(8'h90);
    runHead("r1", 1'b0);
    runRead("r1", 32'h90909090, 8'h90);

    // Run 2: still 0x90 in IDLE, restarts at once; per-byte data
    runHead("r2", 1'b1);
    runRead("r2", 32'hECD35195, 8'hD3);
    nextCycle();
    checkOutput("r2.sticky", 32'(IDread_done), 32'd1);
    checkOutput("r2.stay", 32'(state_reg_tb), 32'd0);

    // Run 3: abort with reset in the middle of byte 2
    applyStimulus(8'h90);
    runHead("r3", 1'b0);
    for (int i = 0; i < 9; i++) nextCycle();
    checkOutput("r3.precnt", 32'(IDread_cnt_tb), 32'd2);
    checkOutput("r3.predev", 32'(DevID_tb), 32'h90);
    #2;
    reset = 1'b0;
    #1;
    checkResetValues("r3.abort");
    applyStimulus(8'h00);
    nextCycle();
    nextCycle();
    checkResetValues("r3.hold");
    reset = 1'b1;
    nextCycle();
    checkResetValues("r3.rel");

    // Run 4: clean restart after the abort
    applyStimulus(8'h90);
    runHead("r4", 1'b0);
    runRead("r4", 32'hA1B2C3D4, 8'hB2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
